// File: rtl/eth_mgmt_pkg.sv
// Shared types and constants for the clause-22 MDIO management responder.
package eth_mgmt_pkg;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    typedef enum logic [2:0] {HUNT, ST1, OP, PHYAD, REGAD, TA, DATA} mdio_state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/mdio_sync.sv
// Brings MDC/MDIO into the CLK200 domain and flags each MDC rising edge.
module mdio_sync (
    input  logic CLK200,
    input  logic RST,
    input  logic MDC,
    input  logic MDIO_IN,
    output logic mdc_rise,
    output logic mdio_s
);

    logic mdc_meta_q, mdc_s_q, mdc_prev_q;
    logic mdio_meta_q, mdio_s_q;

    always_ff @(posedge CLK200 or negedge RST) begin
        if (!RST) begin
            mdc_meta_q  <= 1'b0;
            mdc_s_q     <= 1'b0;
            mdc_prev_q  <= 1'b0;
            mdio_meta_q <= 1'b1;
            mdio_s_q    <= 1'b1;
        end else begin
            mdc_meta_q  <= MDC;
            mdc_s_q     <= mdc_meta_q;
            mdc_prev_q  <= mdc_s_q;
            mdio_meta_q <= MDIO_IN;
            mdio_s_q    <= mdio_meta_q;
        end
    end

    // MDIO runs through the same depth as MDC, so it is sampled with the pin-level setup intact
    assign mdc_rise = mdc_s_q & ~mdc_prev_q;
    assign mdio_s   = mdio_s_q;

endmodule

// File: rtl/mdio_responder.sv
// PHY-side clause-22 MDIO responder: frame decode on MDC rises, read drive, and
// strobe interface to an external 32x16 register bank.
module mdio_responder
    import eth_mgmt_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR = 5'd1,
    parameter int         PRE_LEN  = 32,
    parameter int         MIN_HALF = 3
) (
    input  logic        CLK200,
    input  logic        RST,
    input  logic        MDC,
    input  logic        MDIO_IN,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic [4:0]  REG_ADDR,
    output logic        REG_RD,
    input  logic [15:0] REG_RDATA,
    output logic        REG_WE,
    output logic [15:0] REG_WDATA,
    output logic [15:0] FRM_CNT,
    output logic [7:0]  ERR_CNT
);

    localparam int PRE_W = $clog2(PRE_LEN + 1);

    // Read data is captured two cycles after the last REGAD rise; narrower MDC phases race it
    if (MIN_HALF < 2) begin : g_min_half_chk
        $error("MIN_HALF below 2 cannot hold the read-data capture window");
    end

    logic rise, sdi;

    mdio_sync u_sync (
        .CLK200   (CLK200),
        .RST      (RST),
        .MDC      (MDC),
        .MDIO_IN  (MDIO_IN),
        .mdc_rise (rise),
        .mdio_s   (sdi)
    );

    mdio_state_e        state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [PHYAD_W-1:0] phy_q, phy_d;
    logic [REGAD_W-1:0] regad_q, regad_d;
    logic               match_q, match_d;
    logic               ta_q, ta_d;
    logic [DATA_W-1:0]  sh_q, sh_d;
    logic               cap_q, cap_d;
    logic               oe_q, oe_d, out_q, out_d, rd_q, rd_d, we_q, we_d;
    logic [4:0]         addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d, frm_q, frm_d;
    logic [7:0]         err_q, err_d;

    logic [1:0] op_full;
    logic       op_ok, is_read, phy_hit, ta_ok, pre_full, data_last;

    assign op_full   = {op_q[0], sdi};
    assign op_ok     = (op_full == OP_READ) || (op_full == OP_WRITE);
    assign is_read   = (op_q == OP_READ);
    assign phy_hit   = (phy_q == PHY_ADDR);
    assign ta_ok     = ta_q & ~sdi;
    assign pre_full  = (pre_q == PRE_W'(PRE_LEN));
    // Reads spend one extra rise in DATA to release the pad after D0
    assign data_last = is_read ? (cnt_q == 5'd16) : (cnt_q == 5'd15);

    always_ff @(posedge CLK200 or negedge RST) begin
        if (!RST) begin
            state_q <= HUNT;
            pre_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            phy_q   <= '0;
            regad_q <= '0;
            match_q <= 1'b0;
            ta_q    <= 1'b0;
            sh_q    <= '0;
            cap_q   <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b1;
            rd_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            frm_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            phy_q   <= phy_d;
            regad_q <= regad_d;
            match_q <= match_d;
            ta_q    <= ta_d;
            sh_q    <= sh_d;
            cap_q   <= cap_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            frm_q   <= frm_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rise) begin
            case (state_q)
                HUNT:    if (!sdi && pre_full) state_d = ST1;
                ST1:     state_d = sdi ? OP : HUNT;
                OP:      if (cnt_q == 5'd1) state_d = op_ok ? PHYAD : HUNT;
                PHYAD:   if (cnt_q == 5'd4) state_d = REGAD;
                REGAD:   if (cnt_q == 5'd4) state_d = TA;
                TA:      if (cnt_q == 5'd1) state_d = (is_read || ta_ok) ? DATA : HUNT;
                DATA:    if (data_last) state_d = HUNT;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        pre_d   = pre_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        phy_d   = phy_q;
        regad_d = regad_q;
        match_d = match_q;
        ta_d    = ta_q;
        sh_d    = cap_q ? REG_RDATA : sh_q;
        cap_d   = rd_q;
        oe_d    = oe_q;
        out_d   = out_q;
        rd_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        frm_d   = frm_q;
        err_d   = err_q;
        if (rise) begin
            cnt_d = (state_d != state_q || state_q == HUNT) ? 5'd0 : cnt_q + 5'd1;
            case (state_q)
                HUNT: begin
                    if (!sdi)          pre_d = '0;
                    else if (!pre_full) pre_d = pre_q + 1'b1;
                    if (!sdi && pre_full) pre_d = '0;
                end
                OP: begin
                    op_d = op_full;
                    if (cnt_q == 5'd1 && !op_ok) err_d = sat_inc8(err_q);
                end
                PHYAD: phy_d = {phy_q[PHYAD_W-2:0], sdi};
                REGAD: begin
                    regad_d = {regad_q[REGAD_W-2:0], sdi};
                    if (cnt_q == 5'd4) begin
                        match_d = phy_hit;
                        if (is_read && phy_hit) begin
                            addr_d = {regad_q[REGAD_W-2:0], sdi};
                            rd_d   = 1'b1;
                        end
                    end
                end
                TA: begin
                    if (cnt_q == 5'd0) begin
                        ta_d = sdi;
                    end else if (is_read) begin
                        if (match_q) begin
                            oe_d  = 1'b1;
                            out_d = 1'b0;
                        end
                    end else if (!ta_ok && match_q) begin
                        err_d = sat_inc8(err_q);
                    end
                end
                DATA: begin
                    if (is_read) begin
                        if (cnt_q == 5'd16) begin
                            oe_d  = 1'b0;
                            out_d = 1'b1;
                            if (match_q) frm_d = frm_q + 16'd1;
                        end else if (match_q) begin
                            out_d = sh_q[DATA_W-1];
                            sh_d  = {sh_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        sh_d = {sh_q[DATA_W-2:0], sdi};
                        if (cnt_q == 5'd15 && match_q) begin
                            we_d    = 1'b1;
                            addr_d  = regad_q;
                            wdata_d = {sh_q[DATA_W-2:0], sdi};
                            frm_d   = frm_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign MDIO_OUT  = out_q;
    assign MDIO_OE   = oe_q;
    assign REG_ADDR  = addr_q;
    assign REG_RD    = rd_q;
    assign REG_WE    = we_q;
    assign REG_WDATA = wdata_q;
    assign FRM_CNT   = frm_q;
    assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: a station model bit-bangs MDC/MDIO frames
// and a small register bank answers REG_RD strobes.
module tb_mdio_responder;

    logic        CLK200 = 1'b0;
    logic        RST = 1'b0;
    logic        MDC = 1'b0;
    logic        MDIO_IN = 1'b1;
    logic        MDIO_OUT, MDIO_OE, REG_RD, REG_WE;
    logic [4:0]  REG_ADDR;
    logic [15:0] REG_RDATA = 16'h0;
    logic [15:0] REG_WDATA, FRM_CNT;
    logic [7:0]  ERR_CNT;

    always #5 CLK200 = ~CLK200;

    mdio_responder dut (
        .CLK200    (CLK200),
        .RST       (RST),
        .MDC       (MDC),
        .MDIO_IN   (MDIO_IN),
        .MDIO_OUT  (MDIO_OUT),
        .MDIO_OE   (MDIO_OE),
        .REG_ADDR  (REG_ADDR),
        .REG_RD    (REG_RD),
        .REG_RDATA (REG_RDATA),
        .REG_WE    (REG_WE),
        .REG_WDATA (REG_WDATA),
        .FRM_CNT   (FRM_CNT),
        .ERR_CNT   (ERR_CNT)
    );

    logic [15:0] mem [32];
    always @(posedge CLK200) if (REG_RD) REG_RDATA <= mem[REG_ADDR];

    int         rd_tot = 0, we_tot = 0, both_tot = 0;
    logic [4:0] rd_addr_l = '0, we_addr_l = '0;
    logic [15:0] wd_l = '0;
    always @(posedge CLK200) begin
        if (RST) begin
            if (REG_RD) begin
                rd_tot    <= rd_tot + 1;
                rd_addr_l <= REG_ADDR;
            end
            if (REG_WE) begin
                we_tot    <= we_tot + 1;
                we_addr_l <= REG_ADDR;
                wd_l      <= REG_WDATA;
            end
            if (REG_RD && REG_WE) both_tot <= both_tot + 1;
        end
    end

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic oe_rec [100];
    logic out_rec [100];

    // One MDC period: MDIO set while MDC low, rise, fall, then sample what the PHY drives
    task automatic mdc_bit(input logic b, input int half, input int idx);
        MDIO_IN = b;
        repeat (half) @(negedge CLK200);
        MDC = 1'b1;
        repeat (half) @(negedge CLK200);
        MDC = 1'b0;
        oe_rec[idx]  = MDIO_OE;
        out_rec[idx] = MDIO_OUT;
    endtask

    // Bit 0 is a leading idle 0, so base = 1 + npre is the first START bit
    task automatic run_frame(input logic [1:0] st, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [1:0] ta, input logic [15:0] dat,
                             input int npre, input int half, input int stop_at);
        logic bits [$];
        bits.push_back(1'b0);
        repeat (npre) bits.push_back(1'b1);
        for (int i = 1; i >= 0; i--) bits.push_back(st[i]);
        for (int i = 1; i >= 0; i--) bits.push_back(op[i]);
        for (int i = 4; i >= 0; i--) bits.push_back(phy[i]);
        for (int i = 4; i >= 0; i--) bits.push_back(rg[i]);
        for (int i = 1; i >= 0; i--) bits.push_back(ta[i]);
        for (int i = 15; i >= 0; i--) bits.push_back(dat[i]);
        bits.push_back(1'b1);
        for (int i = 0; i < bits.size() && i < stop_at; i++) mdc_bit(bits[i], half, i);
    endtask

    task automatic check_read(input string nm, input logic drive, input logic [15:0] exp, input int npre);
        int base;
        logic early, anyoe, alloe;
        logic [15:0] got;
        base  = 1 + npre;
        early = 1'b0;
        anyoe = 1'b0;
        alloe = 1'b1;
        got   = '0;
        for (int i = 0; i <= base + 14; i++) early |= oe_rec[i];
        chk({nm, "_oe_before_ta2"}, early, 0);
        if (drive) begin
            chk({nm, "_ta2_oe"}, oe_rec[base+15], 1);
            chk({nm, "_ta2_out"}, out_rec[base+15], 0);
            for (int i = 0; i < 16; i++) begin
                got[15-i] = out_rec[base+16+i];
                alloe &= oe_rec[base+16+i];
            end
            chk({nm, "_data"}, got, exp);
            chk({nm, "_data_oe"}, alloe, 1);
            chk({nm, "_release_oe"}, oe_rec[base+32], 0);
            chk({nm, "_release_out"}, out_rec[base+32], 1);
        end else begin
            for (int i = 0; i <= base + 32; i++) anyoe |= oe_rec[i];
            chk({nm, "_no_drive"}, anyoe, 0);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0;
        repeat (3) @(negedge CLK200);
        RST = 1'b1;
        repeat (2) @(negedge CLK200);
    endtask

    typedef struct {
        logic [1:0]  st;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [1:0]  ta;
        logic [15:0] dat;
        int          rd;
        int          we;
        logic [4:0]  addr;
        logic [15:0] wd;
        logic        drive;
        logic [15:0] rdata;
        logic [15:0] frm;
        logic [7:0]  err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int r0, w0;
        logic [15:0] d;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        mem[17] = 16'h7C04;
        mem[0]  = 16'h1140;
        mem[9]  = 16'hA5C3;

        //            st     op     phy    rg      ta     dat       rd we addr  wd       drv  rdata     frm  err
        vecs[0] = '{2'b01, 2'b10, 5'd1, 5'd17, 2'b11, 16'hFFFF, 1, 0, 5'd17, 16'h0,    1'b1, 16'h7C04, 16'd1, 8'd0};
        vecs[1] = '{2'b01, 2'b01, 5'd1, 5'd0,  2'b10, 16'h1140, 0, 1, 5'd0,  16'h1140, 1'b0, 16'h0,    16'd2, 8'd0};
        vecs[2] = '{2'b01, 2'b10, 5'd2, 5'd17, 2'b11, 16'hFFFF, 0, 0, 5'd0,  16'h0,    1'b0, 16'h0,    16'd2, 8'd0};
        vecs[3] = '{2'b01, 2'b10, 5'd1, 5'd17, 2'b11, 16'hFFFF, 1, 0, 5'd17, 16'h0,    1'b1, 16'h7C04, 16'd3, 8'd0};
        vecs[4] = '{2'b01, 2'b01, 5'd1, 5'd5,  2'b00, 16'hABCD, 0, 0, 5'd0,  16'h0,    1'b0, 16'h0,    16'd3, 8'd1};
        vecs[5] = '{2'b01, 2'b11, 5'd1, 5'd9,  2'b11, 16'h0000, 0, 0, 5'd0,  16'h0,    1'b0, 16'h0,    16'd3, 8'd2};
        vecs[6] = '{2'b01, 2'b01, 5'd2, 5'd3,  2'b10, 16'h5555, 0, 0, 5'd0,  16'h0,    1'b0, 16'h0,    16'd3, 8'd2};
        vecs[7] = '{2'b00, 2'b10, 5'd1, 5'd9,  2'b11, 16'hFFFF, 0, 0, 5'd0,  16'h0,    1'b0, 16'h0,    16'd3, 8'd2};
        vecs[8] = '{2'b01, 2'b00, 5'd1, 5'd9,  2'b11, 16'h0000, 0, 0, 5'd0,  16'h0,    1'b0, 16'h0,    16'd3, 8'd3};
        vecs[9] = '{2'b01, 2'b10, 5'd1, 5'd9,  2'b11, 16'hFFFF, 1, 0, 5'd9,  16'h0,    1'b1, 16'hA5C3, 16'd4, 8'd3};

        repeat (3) @(negedge CLK200);
        chk("rst_oe", MDIO_OE, 0);
        chk("rst_out", MDIO_OUT, 1);
        chk("rst_rd", REG_RD, 0);
        chk("rst_we", REG_WE, 0);
        chk("rst_addr", REG_ADDR, 0);
        chk("rst_wdata", REG_WDATA, 0);
        chk("rst_frm", FRM_CNT, 0);
        chk("rst_err", ERR_CNT, 0);
        RST = 1'b1;
        repeat (2) @(negedge CLK200);

        for (int k = 0; k < 10; k++) begin
            r0 = rd_tot;
            w0 = we_tot;
            run_frame(vecs[k].st, vecs[k].op, vecs[k].phy, vecs[k].rg, vecs[k].ta, vecs[k].dat, 32, 5, 1000);
            repeat (4) @(negedge CLK200);
            chk($sformatf("v%0d_rd_pulses", k), rd_tot - r0, vecs[k].rd);
            chk($sformatf("v%0d_we_pulses", k), we_tot - w0, vecs[k].we);
            chk($sformatf("v%0d_frm", k), FRM_CNT, vecs[k].frm);
            chk($sformatf("v%0d_err", k), ERR_CNT, vecs[k].err);
            if (vecs[k].rd != 0) chk($sformatf("v%0d_rd_addr", k), rd_addr_l, vecs[k].addr);
            if (vecs[k].we != 0) begin
                chk($sformatf("v%0d_we_addr", k), we_addr_l, vecs[k].addr);
                chk($sformatf("v%0d_wdata", k), wd_l, vecs[k].wd);
            end
            check_read($sformatf("v%0d", k), vecs[k].drive, vecs[k].rdata, 32);
        end

        // 31-bit preamble must not be accepted
        r0 = rd_tot;
        run_frame(2'b01, 2'b10, 5'd1, 5'd17, 2'b11, 16'hFFFF, 31, 5, 1000);
        repeat (4) @(negedge CLK200);
        chk("pre31_rd", rd_tot - r0, 0);
        chk("pre31_frm", FRM_CNT, 16'd4);
        check_read("pre31", 1'b0, 16'h0, 31);

        // Reset asserted while D8 is on the pad, checked before any CLK200 edge
        run_frame(2'b01, 2'b10, 5'd1, 5'd17, 2'b11, 16'hFFFF, 32, 5, 57);
        d = 16'h7C04;
        chk("midrst_d8_oe", oe_rec[56], 1);
        chk("midrst_d8_out", out_rec[56], d[8]);
        RST = 1'b0;
        #1;
        chk("midrst_oe", MDIO_OE, 0);
        chk("midrst_out", MDIO_OUT, 1);
        chk("midrst_frm", FRM_CNT, 0);
        chk("midrst_err", ERR_CNT, 0);
        repeat (3) @(negedge CLK200);
        RST = 1'b1;
        repeat (2) @(negedge CLK200);
        run_frame(2'b01, 2'b10, 5'd1, 5'd17, 2'b11, 16'hFFFF, 32, 5, 1000);
        repeat (4) @(negedge CLK200);
        check_read("postrst", 1'b1, 16'h7C04, 32);
        chk("postrst_frm", FRM_CNT, 16'd1);

        // Back-to-back reads at a relaxed and at the minimum MDC phase width
        for (int h = 0; h < 2; h++) begin
            int half;
            half = (h == 0) ? 5 : 3;
            do_reset();
            r0 = rd_tot;
            run_frame(2'b01, 2'b10, 5'd1, 5'd17, 2'b11, 16'hFFFF, 32, half, 1000);
            check_read($sformatf("b2b%0d_a", half), 1'b1, 16'h7C04, 32);
            run_frame(2'b01, 2'b10, 5'd1, 5'd9, 2'b11, 16'hFFFF, 32, half, 1000);
            check_read($sformatf("b2b%0d_b", half), 1'b1, 16'hA5C3, 32);
            repeat (4) @(negedge CLK200);
            chk($sformatf("b2b%0d_frm", half), FRM_CNT, 16'd2);
            chk($sformatf("b2b%0d_rd", half), rd_tot - r0, 2);
            chk($sformatf("b2b%0d_addr", half), rd_addr_l, 5'd9);
        end

        chk("rd_we_overlap", both_tot, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
Name: mdio_responder

Overview:
- PHY-side (slave) end of the IEEE 802.3 clause-22 MDIO/MDC management interface, clocked from CLK200.
- Oversamples MDC/MDIO, decodes preamble/start/op/PHY address/register address/turnaround, and answers reads by driving MDIO.
- Presents writes and reads to an external 32x16 register bank through a strobe interface.
- Used as the PHY management model in system benches and as the management target for on-chip MAC/PHY emulation.

Parameters:
PHY_ADDR, 5'd1, PHY address this responder answers to
PRE_LEN, 32, consecutive MDIO ones required before a START is accepted
MIN_HALF, 3, minimum MDC high/low width in CLK200 cycles that is guaranteed to work

Ports:
CLK200  in  1  system clock, 200 MHz
RST  in  1  asynchronous active-low reset
MDC  in  1  management clock from the station (asynchronous to CLK200)
MDIO_IN  in  1  MDIO pad input
MDIO_OUT  out  1  MDIO value driven when MDIO_OE=1
MDIO_OE  out  1  1 = responder drives the MDIO pad
REG_ADDR  out  5  register address for the current REG_RD/REG_WE strobe
REG_RD  out  1  one-cycle read strobe
REG_RDATA  in  16  read data, valid the cycle after REG_RD
REG_WE  out  1  one-cycle write strobe
REG_WDATA  out  16  write data, valid with REG_WE
FRM_CNT  out  16  accepted-frame counter, wraps at 16'hFFFF->0
ERR_CNT  out  8  aborted-frame counter, saturates at 8'hFF

Behaviour:
- Reset: RST is asynchronous active-low (RST=0 resets immediately, without waiting for a CLK200 edge); all state is cleared while RST=0. Reset values: MDIO_OE=0, MDIO_OUT=1, REG_RD=0, REG_WE=0, REG_ADDR=0, REG_WDATA=0, FRM_CNT=0, ERR_CNT=0, state HUNT, preamble count 0.
- Input conditioning:
  - MDC and MDIO_IN each pass through a 2-FF synchronizer.
  - Rising-edge detection on synchronized MDC; one "rise" event per MDC rising edge.
  - MDIO is sampled on the rise event.
  - All frame activity advances only on rise events.
- Output timing: MDIO_OUT/MDIO_OE are registered and update on the CLK200 cycle after the rise event. This is at most 4 CLK200 cycles after the MDC pin rises, and the value holds until the next rise.
- States:
  - HUNT: each sampled 1 increments the preamble count, saturating at PRE_LEN. A 0 when count<PRE_LEN clears the count. A 0 when count==PRE_LEN goes to ST1 (first START bit). Count clears on leaving HUNT.
  - ST1: sample must be 1, then go to OP. A 0 goes to HUNT with no ERR increment, because 00 is treated as idle noise.
  - OP: 2 bits, MSB first. 10=read, 01=write. 00 or 11 increments ERR_CNT and goes to HUNT.
  - PHYAD: 5 bits MSB first, then REGAD.
  - REGAD: 5 bits MSB first. match = (PHYAD==PHY_ADDR).
    - Read and match: on the rise carrying the last REGAD bit, drive REG_ADDR and pulse REG_RD for one cycle. Capture REG_RDATA into a 16-bit shift register on the following cycle.
    - Then go to TA.
  - TA: 2 bits.
    - Read: first TA rise keeps OE=0. Second TA rise sets OE=1 (if match) and MDIO_OUT=0.
    - Write: sampled TA bits must be 1 then 0. Otherwise increment ERR_CNT and go to HUNT with no REG_WE.
  - DATA: 16 bits MSB first.
    - Read and match: each rise shifts out the next bit (D15 on the rise after the second TA bit, D0 last). On the rise after D0, set OE=0 and MDIO_OUT=1.
    - Write: shift in 16 sampled bits. After the 16th bit, if match, pulse REG_WE with REG_ADDR and REG_WDATA for one cycle.
    - Read or write: FRM_CNT+1 if match, then go to HUNT with count 0. The next frame needs a fresh PRE_LEN preamble.
- Non-matching PHYAD: the frame is still tracked to the end (no resync loss). There is no drive, no strobes and no counter change.
- REG_RD and REG_WE are never high in the same cycle. They always last exactly 1 cycle.
- MDC stopping mid-frame: the state is held indefinitely and MDIO_OE stays at its current value. There is no timeout.
- MDC high or low widths shorter than MIN_HALF cycles are unsupported.

Decomposition:
- Package eth_mgmt_pkg:
  - state enum (HUNT, ST1, OP, PHYAD, REGAD, TA, DATA);
  - OP_READ=2'b10, OP_WRITE=2'b01;
  - field widths (PHYAD_W=5, REGAD_W=5, DATA_W=16).
- Sub-module mdio_sync: 2-FF synchronizers for MDC/MDIO plus MDC rise detector. It uses the same CLK200/RST and outputs mdc_rise and mdio_s.

Test Plan:
- 32 ones, 0110, PHYAD 00001, REGAD 10001, REG_RDATA=16'h7C04 -> one REG_RD with REG_ADDR=17; OE rises at the second TA bit with OUT=0; station samples 16'h7C04; OE=0 after D0; FRM_CNT=1.
- Write frame: 32 ones, 0101, PHYAD 1, REGAD 0, TA 10, data 16'h1140 -> single REG_WE with REG_ADDR=0 and REG_WDATA=16'h1140; FRM_CNT+1.
- Read to PHYAD 2 -> MDIO_OE never 1; no REG_RD or REG_WE; counters unchanged. An immediately following valid read to PHYAD 1 is answered correctly.
- 31 ones then a valid-looking frame -> ignored, no strobes. A write with TA=00 -> no REG_WE and ERR_CNT=1. OP=11 -> ERR_CNT+1.
- RST asserted low mid read (during D8) -> MDIO_OE=0 and MDIO_OUT=1 without a CLK200 edge. After release, the next full frame is answered normally.
- Two back-to-back reads at MDC half-period 5 and again at MIN_HALF=3 -> both return the correct data; FRM_CNT=2.
